// File: rtl/addsub_pkg.sv
// Shared types and opcodes for the digit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fas.sv
// Single-bit full adder/subtractor cell; s_op inverts b before the add.
// Latency: purely combinational.
// Backpressure: none, no state.
module fas (
   output logic s,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic s_op
);

   logic b_eff;

   // Conditional inversion of b, then a plain full add.
   always_comb begin
      b_eff = b ^ s_op;
      s     = a ^ b_eff ^ cin;
      cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
   end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit add/subtract, DIGIT bits per cycle through a fas ripple chain.
// Latency: out_valid rises STEPS cycles after the accepting edge; issue interval STEPS+2.
// Backpressure: result held in DONE while out_ready is low; in_ready low outside IDLE.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   // Reject geometries where the operand does not split into whole digits.
   if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
      $error("serial_addsub: WIDTH must be a multiple of DIGIT and DIGIT in 1..WIDTH");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [DIGIT-1:0] dig_s;
   logic [DIGIT:0]   chain_c;

   // The registered carry feeds the bottom of this digit's ripple chain.
   assign chain_c[0] = carry_q;

   // B is already inverted for subtraction at accept, so the cells always add.
   for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      fas u_fas (
         .s    (dig_s[i]),
         .cout (chain_c[i+1]),
         .a    (a_q[i]),
         .b    (b_q[i]),
         .cin  (chain_c[i]),
         .s_op (OP_ADD)
      );
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   // Next-state and datapath: latch operands, shift one digit per RUN cycle, publish on the last.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = a;
               b_d     = (s_op == OP_SUB) ? ~b : b;
               carry_d = (s_op == OP_SUB);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            // New digit enters at the top; after STEPS shifts the LSB digit sits at bit 0.
            acc_d   = WIDTH'({dig_s, acc_q} >> DIGIT);
            carry_d = chain_c[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // The accumulator is separate from sum so the output never shows a partial result.
               sum_d   = acc_d;
               cout_d  = chain_c[DIGIT];
               ovf_d   = chain_c[DIGIT] ^ chain_c[DIGIT-1];
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset that also clears any partial operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at 8/1 and 16/4 geometries.
// Latency: checks out_valid rises exactly STEPS cycles after accept.
// Backpressure: directed stall on the 8-bit unit, patterned out_ready on the 16-bit unit.
module tb_serial_addsub;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          acc;
   } exp_t;

   logic clk;
   logic rst;

   logic        in_valid8, in_ready8, s8, out_valid8, out_ready8, cout8, ovf8;
   logic [7:0]  a8, b8, sum8;
   logic        in_valid16, in_ready16, s16, out_valid16, out_ready16, cout16, ovf16;
   logic [15:0] a16, b16, sum16;

   exp_t q8[$];
   exp_t q16[$];
   bit   seen8, seen16;
   int   cyc;
   int   checks;
   int   errors;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .s_op(s8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .s_op(s16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .sum(sum16), .cout(cout16), .ovf(ovf16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present one operand set, wait (bounded) for acceptance, then push the expected result.
   task automatic issue(input int which, input logic [15:0] ia, input logic [15:0] ib,
                        input logic op, input logic [15:0] es, input logic ec, input logic eo);
      bit   got;
      exp_t e;
      got = 1'b0;
      @(posedge clk); #1;
      if (which == 0) begin
         a8 = ia[7:0]; b8 = ib[7:0]; s8 = op; in_valid8 = 1'b1;
      end else begin
         a16 = ia; b16 = ib; s16 = op; in_valid16 = 1'b1;
      end
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if ((which == 0) ? in_ready8 : in_ready16) got = 1'b1;
      end
      if (!got) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc + 1;
         if (which == 0) q8.push_back(e); else q16.push_back(e);
      end
      @(posedge clk); #1;
      if (which == 0) in_valid8 = 1'b0; else in_valid16 = 1'b0;
   endtask

   task automatic wait_idle8();
      bit got;
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (in_ready8) got = 1'b1;
      end
      if (!got) chk("w8_idle_timeout", 32'd0, 32'd1);
   endtask

   // Monitor for the 8-bit unit: latency on first presentation, values on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid8 && !seen8) begin
            seen8 = 1'b1;
            if (q8.size() == 0) chk("w8_unexpected_out", 32'd1, 32'd0);
            else chk("w8_latency", 32'(cyc - q8[0].acc), 32'd8);
         end
         if (out_valid8 && out_ready8) begin
            seen8 = 1'b0;
            if (q8.size() != 0) begin
               e = q8.pop_front();
               chk("w8_sum", 32'(sum8), 32'(e.sum[7:0]));
               chk("w8_cout", 32'(cout8), 32'(e.cout));
               chk("w8_ovf", 32'(ovf8), 32'(e.ovf));
            end
         end
      end
   end

   // Monitor for the 16-bit unit.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid16 && !seen16) begin
            seen16 = 1'b1;
            if (q16.size() == 0) chk("w16_unexpected_out", 32'd1, 32'd0);
            else chk("w16_latency", 32'(cyc - q16[0].acc), 32'd4);
         end
         if (out_valid16 && out_ready16) begin
            seen16 = 1'b0;
            if (q16.size() != 0) begin
               e = q16.pop_front();
               chk("w16_sum", 32'(sum16), 32'(e.sum));
               chk("w16_cout", 32'(cout16), 32'(e.cout));
               chk("w16_ovf", 32'(ovf16), 32'(e.ovf));
            end
         end
      end
   end

   // Fixed stall pattern on the 16-bit consumer: low 3 of every 7 cycles.
   initial begin
      out_ready16 = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready16 = ((cyc % 7) >= 3);
      end
   end

   initial begin
      bit got;
      bit bad;
      checks = 0; errors = 0; cyc = 0; seen8 = 1'b0; seen16 = 1'b0;
      rst = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; out_ready8 = 1'b1;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready8), 32'd0);
      chk("rst_out_valid", 32'(out_valid8), 32'd0);
      chk("rst_sum", 32'(sum8), 32'd0);
      chk("rst_cout", 32'(cout8), 32'd0);
      chk("rst_ovf", 32'(ovf8), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready8", 32'(in_ready8), 32'd1);
      chk("post_rst_in_ready16", 32'(in_ready16), 32'd1);

      // Directed 8-bit vectors.
      issue(0, 16'h05, 16'h03, 1'b0, 16'h08, 1'b0, 1'b0);
      issue(0, 16'h03, 16'h05, 1'b1, 16'hFE, 1'b0, 1'b0);
      issue(0, 16'h05, 16'h03, 1'b1, 16'h02, 1'b1, 1'b0);
      issue(0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1);
      issue(0, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1);
      issue(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0);
      issue(0, 16'h80, 16'h80, 1'b0, 16'h00, 1'b1, 1'b1);
      issue(0, 16'h00, 16'h00, 1'b1, 16'h00, 1'b1, 1'b0);

      // Backpressure: 5-cycle stall in DONE with a competing in_valid.
      wait_idle8();
      @(posedge clk); #1 out_ready8 = 1'b0;
      issue(0, 16'h33, 16'h44, 1'b0, 16'h77, 1'b0, 1'b0);
      got = 1'b0;
      for (int n = 0; n < 30 && !got; n++) begin
         @(negedge clk);
         if (out_valid8) got = 1'b1;
      end
      chk("stall_reach_done", 32'(got), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_out_valid", 32'(out_valid8), 32'd1);
         chk("stall_in_ready", 32'(in_ready8), 32'd0);
         chk("stall_sum", 32'(sum8), 32'h77);
         chk("stall_cout", 32'(cout8), 32'd0);
         chk("stall_ovf", 32'(ovf8), 32'd0);
         if (i == 0) begin
            a8 = 8'h01; b8 = 8'h01; s8 = 1'b0; in_valid8 = 1'b1;
         end
      end
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready8), 32'd1);
      chk("release_out_valid", 32'(out_valid8), 32'd0);
      issue(0, 16'h40, 16'h40, 1'b0, 16'h80, 1'b0, 1'b1);

      // Reset during RUN at cnt=3 aborts without a result.
      wait_idle8();
      issue(0, 16'hAA, 16'h11, 1'b0, 16'hBB, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_in_ready_in_rst", 32'(in_ready8), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      q8.delete();
      seen8 = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready8), 32'd1);
      chk("abort_sum", 32'(sum8), 32'd0);
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid8) bad = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_out_valid", 32'(bad), 32'd0);
      issue(0, 16'h10, 16'h20, 1'b0, 16'h30, 1'b0, 1'b0);

      // Directed 16-bit vectors, 4 bits per cycle, consumer stalls throughout.
      issue(1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      issue(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      issue(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      issue(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      issue(1, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      issue(1, 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0);
      issue(1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      issue(1, 16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0);
      issue(1, 16'h1000, 16'h0FFF, 1'b1, 16'h0001, 1'b1, 1'b0);
      issue(1, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1);

      // Drain both scoreboards.
      got = 1'b0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk);
         if (q8.size() == 0 && q16.size() == 0) got = 1'b1;
      end
      chk("drain_scoreboard", 32'(q8.size() + q16.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
